// File: rtl/serial_pkg.sv
// Shared types and constants for the serial nibble receiver.
// State encodings are fixed so they stay stable across debug tooling.
package serial_pkg;

    localparam int NIBBLE_W = 4;
    localparam int BITCNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DATA   = 2'b01,
        ST_PARITY = 2'b10
    } state_t;

    // Even parity: data ones plus the parity bit must sum to an even count.
    function automatic logic even_parity_ok(input logic [NIBBLE_W-1:0] data, input logic par);
        return ((^data) == par);
    endfunction

endpackage

// File: rtl/nibble_shift_reg.sv
// 4-bit serial shift register; the first bit lands in bit 0 (LSB_FIRST=1) or bit 3.
// One-cycle update; clear beats shift; 'shifted' previews the value after a shift.
module nibble_shift_reg
    import serial_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                shift,
    input  logic                bit_in,
    output logic [NIBBLE_W-1:0] value,
    output logic [NIBBLE_W-1:0] shifted
);

    assign shifted = LSB_FIRST ? {bit_in, value[NIBBLE_W-1:1]}
                               : {value[NIBBLE_W-2:0], bit_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (shift) begin
            value <= shifted;
        end
    end

endmodule

// File: rtl/serial_nibble_receiver.sv
// Frames start + 4 data bits (+ even parity) into a checked nibble for the downstream register.
// Outputs registered one cycle after the final bit; bit_valid low simply stalls the frame.
module serial_nibble_receiver
    import serial_pkg::*;
#(
    parameter bit PARITY_EN = 1'b1,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic [NIBBLE_W-1:0] nibble,
    output logic                nibble_valid,
    output logic                parity_err,
    output logic                busy
);

    state_t                state, next_state;
    logic [BITCNT_W-1:0]   cnt, cnt_next;
    logic                  sr_clear, sr_shift;
    logic                  commit, perr;
    logic [NIBBLE_W-1:0]   sr_value, sr_shifted, commit_data;

    nibble_shift_reg #(.LSB_FIRST(LSB_FIRST)) u_shift (
        .clk     (clk),
        .reset   (reset),
        .clear   (sr_clear),
        .shift   (sr_shift),
        .bit_in  (bit_in),
        .value   (sr_value),
        .shifted (sr_shifted)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // start always wins: it restarts the frame and discards any same-cycle bit.
    always_comb begin
        next_state  = state;
        cnt_next    = cnt;
        sr_clear    = 1'b0;
        sr_shift    = 1'b0;
        commit      = 1'b0;
        perr        = 1'b0;
        commit_data = sr_value;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_DATA;
                    cnt_next   = '0;
                    sr_clear   = 1'b1;
                end
            end
            ST_DATA: begin
                if (start) begin
                    cnt_next = '0;
                    sr_clear = 1'b1;
                end else if (bit_valid) begin
                    sr_shift = 1'b1;
                    cnt_next = cnt + 1'b1;
                    if (cnt == BITCNT_W'(NIBBLE_W - 1)) begin
                        cnt_next = '0;
                        if (PARITY_EN) begin
                            next_state = ST_PARITY;
                        end else begin
                            next_state  = ST_IDLE;
                            commit      = 1'b1;
                            commit_data = sr_shifted;
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (start) begin
                    next_state = ST_DATA;
                    cnt_next   = '0;
                    sr_clear   = 1'b1;
                end else if (bit_valid) begin
                    next_state = ST_IDLE;
                    if (even_parity_ok(sr_value, bit_in)) begin
                        commit = 1'b1;
                    end else begin
                        perr = 1'b1;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nibble       <= '0;
            nibble_valid <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            if (commit) begin
                nibble <= commit_data;
            end
            nibble_valid <= commit;
            parity_err   <= perr;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
